// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the sliding-window generator.
//   - default geometry of the MNIST conv layer (28x28 frame, 5x5 window)
//   - helpers that derive the output-map size and counter widths from parameters
//   - FSM state enum shared by the window generator
//   - idx(): flat element index of window element (i,j)
package conv_pkg;

  localparam int DEF_WIDTH     = 28;
  localparam int DEF_HEIGHT    = 28;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_CHANNELS  = 1;
  localparam int DEF_K         = 5;
  localparam int DEF_STRIDE    = 1;

  typedef enum logic {FILL, RUN} state_t;

  // Number of window positions along one axis of length n.
  function automatic int out_dim(input int n, input int k, input int s);
    return (n - k) / s + 1;
  endfunction

  // Width of a counter holding 0..n-1; at least one bit so a single-entry
  // counter still has a legal declaration.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flat position of window element (row offset i, column offset j).
  function automatic int idx(input int i, input int j, input int k);
    return i * k + j;
  endfunction

endpackage

// File: rtl/conv_line_mem.sv
// conv_line_mem: circular store of the K-1 most recent input rows.
//   clk      : clock
//   wr_en    : write data_in at (wr_slot, col)
//   wr_slot  : row slot being written (rotation owned by the parent)
//   col      : column for both the write and the parallel reads
//   wr_data  : pixel to store
//   rd_data  : pixel at column col of every slot, slot s at [s*PIX_BITS +: PIX_BITS]
// Reads are combinational and return the value held before this cycle's write,
// which lets the parent read the oldest row out of the slot it is overwriting.
module conv_line_mem
  import conv_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ROWS     = DEF_K - 1,
  parameter int PIX_BITS = DEF_DATA_BITS,
  parameter int COL_W    = cnt_bits(WIDTH),
  parameter int SLOT_W   = cnt_bits(ROWS)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [SLOT_W-1:0]        wr_slot,
  input  logic [COL_W-1:0]         col,
  input  logic [PIX_BITS-1:0]      wr_data,
  output logic [ROWS*PIX_BITS-1:0] rd_data
);

  logic [PIX_BITS-1:0] mem [ROWS][WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_slot][col] <= wr_data;
  end

  always_comb begin
    for (int s = 0; s < ROWS; s++) begin
      rd_data[s*PIX_BITS +: PIX_BITS] = mem[s][col];
    end
  end

endmodule

// File: rtl/conv_window_buf.sv
// conv_window_buf: streaming KxK sliding-window generator with stride.
//   clk, rst_n  : clock, synchronous active-low reset
//   valid_in    : data_in carries the next raster-order pixel
//   data_in     : CHANNELS samples of DATA_BITS, channel c at [c*DATA_BITS +: DATA_BITS]
//   window_out  : KxK window, element (i,j) at [(i*K+j)*PIX_BITS +: PIX_BITS]
//   valid_out   : window_out/out_row/out_col valid this cycle (1 cycle after acceptance)
//   out_row/col : output-map coordinates of the window
//   frame_done  : pulses with the last window of a frame
module conv_window_buf
  import conv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int K         = DEF_K,
  parameter int STRIDE    = DEF_STRIDE,
  localparam int PIX_BITS = CHANNELS * DATA_BITS,
  localparam int OUT_W    = out_dim(WIDTH, K, STRIDE),
  localparam int OUT_H    = out_dim(HEIGHT, K, STRIDE),
  localparam int OR_W     = $clog2(OUT_H) + 1,
  localparam int OC_W     = $clog2(OUT_W) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [PIX_BITS-1:0]       data_in,
  output logic [K*K*PIX_BITS-1:0]   window_out,
  output logic                      valid_out,
  output logic [OR_W-1:0]           out_row,
  output logic [OC_W-1:0]           out_col,
  output logic                      frame_done
);

  localparam int COL_W  = cnt_bits(WIDTH);
  localparam int ROW_W  = cnt_bits(HEIGHT);
  localparam int SLOT_W = cnt_bits(K - 1);
  localparam int PH_W   = cnt_bits(STRIDE);

  state_t state, state_nxt;

  logic [COL_W-1:0]  in_col;
  logic [ROW_W-1:0]  in_row;
  logic [SLOT_W-1:0] wr_slot;
  logic [PH_W-1:0]   col_ph;
  logic [PH_W-1:0]   row_ph;
  logic [OR_W-1:0]   row_idx;
  logic [OC_W-1:0]   col_idx;

  logic [(K-1)*PIX_BITS-1:0] line_rd;
  logic [PIX_BITS-1:0]       new_col [K];
  logic [PIX_BITS-1:0]       win     [K][K];
  logic [PIX_BITS-1:0]       win_nxt [K][K];
  logic [K*K*PIX_BITS-1:0]   win_flat;

  logic col_last, row_last, col_ok, emit, frame_last;
  int   sel;

  assign col_last   = (in_col == COL_W'(WIDTH - 1));
  assign row_last   = (in_row == ROW_W'(HEIGHT - 1));
  assign col_ok     = (in_col >= COL_W'(K - 1));
  // col_ph/row_ph hold (position - (K-1)) mod STRIDE, so a zero phase marks a
  // window whose top-left corner lies on the stride grid.
  assign emit       = valid_in && (state == RUN) && col_ok && (col_ph == '0) && (row_ph == '0);
  assign frame_last = emit && (row_idx == OR_W'(OUT_H - 1)) && (col_idx == OC_W'(OUT_W - 1));

  conv_line_mem #(
    .WIDTH    (WIDTH),
    .ROWS     (K - 1),
    .PIX_BITS (PIX_BITS),
    .COL_W    (COL_W),
    .SLOT_W   (SLOT_W)
  ) u_line_mem (
    .clk     (clk),
    .wr_en   (valid_in),
    .wr_slot (wr_slot),
    .col     (in_col),
    .wr_data (data_in),
    .rd_data (line_rd)
  );

  // The slot being overwritten holds the oldest row, so window row i comes
  // from slot (wr_slot + i) mod (K-1); the bottom row is the incoming pixel.
  always_comb begin
    sel = 0;
    for (int i = 0; i < K - 1; i++) begin
      sel        = (int'(wr_slot) + i) % (K - 1);
      new_col[i] = line_rd[sel*PIX_BITS +: PIX_BITS];
    end
    new_col[K-1] = data_in;
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        win_nxt[i][j] = win[i][j+1];
      end
      win_nxt[i][K-1] = new_col[i];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_flat[idx(i, j, K)*PIX_BITS +: PIX_BITS] = win_nxt[i][j];
      end
    end
  end

  // Window shift register: needs no reset, since FILL guarantees every column
  // is refilled from the current frame before any window is emitted.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win[i][j] <= win_nxt[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (valid_in && col_last) begin
      case (state)
        FILL:    if (in_row == ROW_W'(K - 2)) state_nxt = RUN;
        RUN:     if (row_last) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Raster position, stride phases and output-map indices.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_col  <= '0;
      in_row  <= '0;
      wr_slot <= '0;
      col_ph  <= '0;
      row_ph  <= '0;
      row_idx <= '0;
      col_idx <= '0;
    end else if (valid_in) begin
      if (col_last) begin
        in_col  <= '0;
        col_ph  <= '0;
        col_idx <= '0;
        if (row_last) begin
          in_row  <= '0;
          row_ph  <= '0;
          row_idx <= '0;
          wr_slot <= '0;
        end else begin
          in_row  <= in_row + 1'b1;
          wr_slot <= (wr_slot == SLOT_W'(K - 2)) ? '0 : wr_slot + 1'b1;
          if (state == RUN) begin
            row_ph <= (row_ph == PH_W'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
            if (row_ph == '0) row_idx <= row_idx + 1'b1;
          end
        end
      end else begin
        in_col <= in_col + 1'b1;
        if (col_ok) col_ph <= (col_ph == PH_W'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
        if (emit)   col_idx <= col_idx + 1'b1;
      end
    end
  end

  // Output registers: window and coordinates load only on emission so they
  // hold through stalls and non-emitting pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window_out <= '0;
      valid_out  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= emit;
      frame_done <= frame_last;
      if (emit) begin
        window_out <= win_flat;
        out_row    <= row_idx;
        out_col    <= col_idx;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buf.sv
// tb_conv_window_buf: directed bench for conv_window_buf.
// Four instances cover 4x4/K3/S1, 6x6/K3/S2, the 28x28/K5 default and a
// 3-channel 4x4/K2 configuration.
module tb_conv_window_buf;

  typedef struct packed {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [71:0] win;
    logic        fd;
  } win_rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        valid_a, valid_out_a, fd_a;
  logic [7:0]  data_a;
  logic [71:0] win_a;
  logic [1:0]  row_a, col_a;

  logic        valid_b, valid_out_b, fd_b;
  logic [7:0]  data_b;
  logic [71:0] win_b;
  logic [1:0]  row_b, col_b;

  logic         valid_c, valid_out_c, fd_c;
  logic [7:0]   data_c;
  logic [199:0] win_c;
  logic [5:0]   row_c, col_c;

  logic        valid_d, valid_out_d, fd_d;
  logic [23:0] data_d;
  logic [95:0] win_d;
  logic [2:0]  row_d, col_d;

  conv_window_buf #(.WIDTH(4), .HEIGHT(4), .DATA_BITS(8), .CHANNELS(1), .K(3), .STRIDE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_a), .data_in(data_a), .window_out(win_a),
    .valid_out(valid_out_a), .out_row(row_a), .out_col(col_a), .frame_done(fd_a));

  conv_window_buf #(.WIDTH(6), .HEIGHT(6), .DATA_BITS(8), .CHANNELS(1), .K(3), .STRIDE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_b), .data_in(data_b), .window_out(win_b),
    .valid_out(valid_out_b), .out_row(row_b), .out_col(col_b), .frame_done(fd_b));

  conv_window_buf dut_c (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_c), .data_in(data_c), .window_out(win_c),
    .valid_out(valid_out_c), .out_row(row_c), .out_col(col_c), .frame_done(fd_c));

  conv_window_buf #(.WIDTH(4), .HEIGHT(4), .DATA_BITS(8), .CHANNELS(3), .K(2), .STRIDE(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_d), .data_in(data_d), .window_out(win_d),
    .valid_out(valid_out_d), .out_row(row_d), .out_col(col_d), .frame_done(fd_d));

  int checks   = 0;
  int failures = 0;

  win_rec_t tab_a [4];
  win_rec_t tab_b [4];
  win_rec_t q_a [$];
  win_rec_t q_b [$];

  // Collect every emitted window of the two table-checked instances.
  always @(negedge clk) begin
    if (rst_n && valid_out_a) q_a.push_back({row_a, col_a, win_a, fd_a});
    if (rst_n && valid_out_b) q_b.push_back({row_b, col_b, win_b, fd_b});
  end

  function automatic logic [71:0] w9(input int e0, input int e1, input int e2,
                                     input int e3, input int e4, input int e5,
                                     input int e6, input int e7, input int e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [71:0] add100(input logic [71:0] w);
    logic [71:0] r;
    r = w;
    for (int b = 0; b < 9; b++) r[b*8 +: 8] = w[b*8 +: 8] + 8'd100;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus_a(input logic v, input int d);
    valid_a = v;
    data_a  = 8'(d);
    @(negedge clk);
  endtask

  task automatic check_queue_a(input string name, input int start, input bit plus100);
    win_rec_t e;
    for (int k = 0; k < 4; k++) begin
      e = tab_a[k];
      if (plus100) e.win = add100(e.win);
      if (start + k < q_a.size())
        check_output($sformatf("%s_win%0d", name, k), 256'(q_a[start+k]), 256'(e));
      else
        check_output($sformatf("%s_missing%0d", name, k), 256'(0), 256'(1));
    end
  endtask

  initial begin
    int n, iter, k, exp_r, exp_c, bad_valid, early_valid, bad_win, bad_rc, fd_count, fd_pos;
    bit idle, exp_v;
    logic [71:0] last_w;

    tab_a[0] = {2'd0, 2'd0, w9(0, 1, 2, 4, 5, 6, 8, 9, 10), 1'b0};
    tab_a[1] = {2'd0, 2'd1, w9(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
    tab_a[2] = {2'd1, 2'd0, w9(4, 5, 6, 8, 9, 10, 12, 13, 14), 1'b0};
    tab_a[3] = {2'd1, 2'd1, w9(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b1};
    tab_b[0] = {2'd0, 2'd0, w9(0, 1, 2, 6, 7, 8, 12, 13, 14), 1'b0};
    tab_b[1] = {2'd0, 2'd1, w9(2, 3, 4, 8, 9, 10, 14, 15, 16), 1'b0};
    tab_b[2] = {2'd1, 2'd0, w9(12, 13, 14, 18, 19, 20, 24, 25, 26), 1'b0};
    tab_b[3] = {2'd1, 2'd1, w9(14, 15, 16, 20, 21, 22, 26, 27, 28), 1'b1};

    rst_n = 1'b0;
    valid_a = 0; data_a = 0; valid_b = 0; data_b = 0;
    valid_c = 0; data_c = 0; valid_d = 0; data_d = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_output("reset_a", 256'({valid_out_a, fd_a, row_a, col_a, win_a}), 256'(0));

    // Test 1: 4x4, K=3, one window per cycle once emitting starts.
    k = 0;
    for (int p = 0; p < 16; p++) begin
      apply_stimulus_a(1'b1, p);
      exp_v = (p == 10 || p == 11 || p == 14 || p == 15);
      check_output($sformatf("t1_valid_px%0d", p), 256'(valid_out_a), 256'(exp_v));
      if (exp_v) begin
        check_output($sformatf("t1_win%0d", k), 256'({row_a, col_a, win_a, fd_a}), 256'(tab_a[k]));
        k++;
      end else begin
        check_output($sformatf("t1_fd_low_px%0d", p), 256'(fd_a), 256'(0));
      end
    end
    apply_stimulus_a(1'b0, 0);

    // Test 3: same frame with random idle cycles.
    q_a.delete();
    n = 0; iter = 0;
    while (n < 16 && iter < 400) begin
      idle   = ($urandom_range(0, 9) < 4);
      last_w = win_a;
      apply_stimulus_a(!idle, n);
      if (idle) begin
        check_output("t3_valid_after_idle", 256'(valid_out_a), 256'(0));
        check_output("t3_window_hold", 256'(win_a), 256'(last_w));
      end else begin
        n++;
      end
      iter++;
    end
    check_output("t3_pixels_accepted", 256'(n), 256'(16));
    apply_stimulus_a(1'b0, 0);
    check_output("t3_count", 256'(q_a.size()), 256'(4));
    check_queue_a("t3", 0, 1'b0);

    // Test 4: two frames back to back, second frame 100..115.
    q_a.delete();
    for (int p = 0; p < 32; p++) apply_stimulus_a(1'b1, (p < 16) ? p : 100 + p - 16);
    apply_stimulus_a(1'b0, 0);
    apply_stimulus_a(1'b0, 0);
    check_output("t4_count", 256'(q_a.size()), 256'(8));
    check_queue_a("t4_f1", 0, 1'b0);
    check_queue_a("t4_f2", 4, 1'b1);
    if (q_a.size() > 4)
      check_output("t4_f2_first", 256'(q_a[4].win), 256'(w9(100, 101, 102, 104, 105, 106, 108, 109, 110)));

    // Test 2: 6x6, K=3, stride 2.
    for (int p = 0; p < 36; p++) begin
      valid_b = 1'b1; data_b = 8'(p);
      @(negedge clk);
    end
    valid_b = 1'b0;
    repeat (2) @(negedge clk);
    check_output("t2_count", 256'(q_b.size()), 256'(4));
    for (int j = 0; j < 4; j++) begin
      if (j < q_b.size()) check_output($sformatf("t2_win%0d", j), 256'(q_b[j]), 256'(tab_b[j]));
    end

    // Test 6: three channels, pixel n = {n+32, n+16, n}, K=2.
    k = 0; bad_win = 0;
    for (int p = 0; p < 16; p++) begin
      valid_d = 1'b1;
      data_d  = {8'(p + 32), 8'(p + 16), 8'(p)};
      @(negedge clk);
      if (valid_out_d) begin
        if (k == 0)
          check_output("t6_first_win", 256'(win_d),
                       256'({24'h251505, 24'h241404, 24'h211101, 24'h201000}));
        check_output($sformatf("t6_rc%0d", k), 256'({row_d, col_d}), 256'({3'(k / 3), 3'(k % 3)}));
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            for (int ch = 0; ch < 3; ch++)
              if (win_d[((i*2+j)*24 + ch*8) +: 8] !== 8'(((k/3)+i)*4 + (k%3) + j + 16*ch))
                bad_win++;
        k++;
      end
    end
    valid_d = 1'b0;
    @(negedge clk);
    check_output("t6_count", 256'(k), 256'(9));
    check_output("t6_channel_slices", 256'(bad_win), 256'(0));

    // Test 5: defaults, reset after 300 pixels, then a full frame.
    for (int p = 0; p < 300; p++) begin
      valid_c = 1'b1; data_c = 8'(p);
      @(negedge clk);
    end
    valid_c = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_output("t5_reset_state", 256'({valid_out_c, fd_c, row_c, col_c, win_c}), 256'(0));

    k = 0; bad_valid = 0; early_valid = 0; bad_win = 0; bad_rc = 0; fd_count = 0; fd_pos = -1;
    for (int p = 0; p < 784; p++) begin
      valid_c = 1'b1; data_c = 8'(p);
      @(negedge clk);
      exp_v = ((p / 28) >= 4) && ((p % 28) >= 4);
      if (valid_out_c !== exp_v) bad_valid++;
      if (p < 112 && valid_out_c) early_valid++;
      if (valid_out_c) begin
        exp_r = k / 24; exp_c = k % 24;
        if (row_c !== 6'(exp_r) || col_c !== 6'(exp_c)) bad_rc++;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            if (win_c[(i*5+j)*8 +: 8] !== 8'((exp_r + i)*28 + exp_c + j)) bad_win++;
        if (fd_c) begin fd_count++; fd_pos = k; end
        k++;
      end else if (fd_c) begin
        fd_count++;
      end
    end
    valid_c = 1'b0;
    @(negedge clk);
    check_output("t5_no_early_output", 256'(early_valid), 256'(0));
    check_output("t5_valid_pattern", 256'(bad_valid), 256'(0));
    check_output("t5_window_count", 256'(k), 256'(576));
    check_output("t5_coord_sweep", 256'(bad_rc), 256'(0));
    check_output("t5_window_content", 256'(bad_win), 256'(0));
    check_output("t5_frame_done_count", 256'(fd_count), 256'(1));
    check_output("t5_frame_done_pos", 256'(fd_pos), 256'(575));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_buf.md
Name: conv_window_buf

Overview:
- Parametrised streaming sliding-window generator for the convolution layers of the MNIST CNN pipeline.
- Accepts one raster-order pixel per valid_in beat. A pixel is CHANNELS packed samples of DATA_BITS each.
- Emits a flattened KxK window, with optional stride, to the downstream conv MAC stage.
- Adds an input-valid stall, stride support, multi-channel pixels, window coordinates and a frame-done strobe.

Parameters:
- WIDTH, 28, frame width in pixels
- HEIGHT, 28, frame height in pixels
- DATA_BITS, 8, bits per channel sample
- CHANNELS, 1, samples packed per pixel
- K, 5, window edge; legal range 2 <= K <= min(WIDTH, HEIGHT)
- STRIDE, 1, window step in both axes; legal range 1 <= STRIDE <= K
- Derived: PIX_BITS = CHANNELS*DATA_BITS; OUT_W = (WIDTH-K)/STRIDE+1; OUT_H = (HEIGHT-K)/STRIDE+1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low; clock clk
- valid_in  in  1  data_in holds a new pixel this cycle
- data_in  in  PIX_BITS  pixel; channel c sits at [c*DATA_BITS +: DATA_BITS]
- window_out  out  K*K*PIX_BITS  window; element (i,j) sits at [(i*K+j)*PIX_BITS +: PIX_BITS]; i = row offset from top, j = column offset from left
- valid_out  out  1  window_out, out_row and out_col are valid this cycle
- out_row  out  $clog2(OUT_H)+1  output-map row index of the window
- out_col  out  $clog2(OUT_W)+1  output-map column index of the window
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset values: window_out=0, valid_out=0, out_row=0, out_col=0, frame_done=0. Input row/column counters clear to 0 and the FSM enters FILL.
- Input position: internal counters (in_row, in_col) track the raster position of each accepted pixel.
  - They advance only when valid_in=1.
  - in_col wraps at WIDTH-1 and increments in_row; in_row wraps at HEIGHT-1, ending the frame.
- Storage: K-1 previous rows are held in a circular line buffer; the current row is written as it arrives. No frame-sized storage.
- Emission condition: the window with top-left (r,c) is emitted when the pixel at (r+K-1, c+K-1) is accepted, provided that:
  - r <= HEIGHT-K and c <= WIDTH-K
  - r mod STRIDE = 0 and c mod STRIDE = 0
- Latency: exactly 1 cycle. valid_out rises on the clock edge after the accepting edge.
  - out_row = r/STRIDE, out_col = c/STRIDE.
  - window_out carries input pixel (r+i, c+j) at element (i,j).
- No window ever spans a row wrap. Columns c > WIDTH-K produce no output.
- FSM states:
  - FILL: in_row < K-1; accepts pixels; valid_out stays 0. Moves to RUN on acceptance of the pixel (K-2, WIDTH-1).
  - RUN: emits per the rule above. On acceptance of (HEIGHT-1, WIDTH-1), returns to FILL with counters cleared.
- Stall: valid_in=0 holds all state. The next cycle has valid_out=0 and frame_done=0; window_out, out_row and out_col hold their last values.
- Frame done: frame_done=1 in the same cycle as the window with out_row=OUT_H-1, out_col=OUT_W-1.
  - Any trailing rows or columns not reachable at the given STRIDE are still consumed before the next frame starts.
- Back-to-back frames: the pixel following (HEIGHT-1, WIDTH-1) is (0,0) of the next frame, with no bubble required. Line buffer contents from the previous frame are never emitted.
- Reset mid-frame: all partial state is discarded; the first accepted pixel after reset is (0,0).
- Throughput: one pixel accepted per cycle sustained; there is no backpressure input.

Decomposition:
- Shared package conv_pkg:
  - localparams for PIX_BITS, OUT_W, OUT_H and counter widths
  - FSM state enum {FILL, RUN}
  - window element index function idx(i,j) = i*K+j
- One sub-module, conv_line_mem: circular (K-1) x WIDTH x PIX_BITS row store.
  - Interface: write port at (row slot, col); K-1 parallel column reads at col.
  - Parent owns the rotating slot pointer and a KxK register array that shifts left by one column per accepted pixel.

Test Plan:
1. WIDTH=HEIGHT=4, K=3, STRIDE=1, pixels 0..15 on consecutive cycles:
   - exactly 4 windows, at (0,0), (0,1), (1,0), (1,1);
   - first window = {0,1,2,4,5,6,8,9,10}, valid_out asserted the cycle after pixel 10;
   - frame_done pulses once, with the window after pixel 15.
2. WIDTH=HEIGHT=6, K=3, STRIDE=2, pixels 0..35:
   - 4 windows with out_row/out_col (0,0), (0,1), (1,0), (1,1);
   - window (1,1) = {14,15,16,20,21,22,26,27,28}.
3. Test 1 repeated with pseudo-random valid_in gaps (~40% idle): identical window sequence; valid_out never high in the cycle after an idle cycle.
4. Two frames back-to-back, the second using values 100..115: the second frame's first window = {100,101,102,104,105,106,108,109,110}; no window mixes values from both frames.
5. Defaults (28x28, K=5, STRIDE=1), reset asserted after 300 pixels, then a full frame: no output during the first 4 rows after reset; 576 windows; frame_done exactly once; out_row/out_col sweep 0..23.
6. CHANNELS=3, WIDTH=HEIGHT=4, K=2, pixel n = {n+32, n+16, n}: channel slices land at the specified offsets; 9 windows.
